// File: rtl/ppu_pkg.sv
// ppu_pkg
//   Shared sizing helpers and constants for the posit processing unit datapaths.
//   - k_size(N)            : width of the signed regime value k
//   - te_size(N,ES)        : width of the signed total exponent te = k*2^ES + exp
//   - frac_full_size(N,ES) : widest fraction any upstream FIR datapath produces
//                            (divider quotient plus guard bits); hidden bit excluded
//   - fir_size(N,ES)       : packed FIR width {sign, te, frac}
//   - posit_special_t      : per-lane special-value tag carried beside FIR words
//   - nar_val(N)           : the NaR bit pattern, right-aligned in 64 bits
package ppu_pkg;

    function automatic int k_size(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int te_size(input int n, input int es);
        return k_size(n) + es + 1;
    endfunction

    function automatic int frac_full_size(input int n, input int es);
        return 3 * (n - es) - 10;
    endfunction

    function automatic int fir_size(input int n, input int es);
        return 1 + te_size(n, es) + frac_full_size(n, es);
    endfunction

    // 2'b11 is reserved and treated as NaR by consumers (only bit 1 is tested).
    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        ZERO   = 2'b01,
        NAR    = 2'b10
    } posit_special_t;

    function automatic logic [63:0] nar_val(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/fir_to_posit_lane.sv
// fir_to_posit_lane
//   One lane of the FIR-to-posit converter: the S1/S2/S3 combinational logic
//   and the data registers behind each stage. Flow control lives in the top;
//   this lane only loads a stage when its load enable is high.
//   S1: decode k/exp, saturation flags, align {regime, exp, frac} into the
//       N-1 bit posit body and extract round/sticky bits.
//   S2: unsigned posit encode (saturation override) and round-up decision.
//   S3: apply rounding, two's-complement sign and the zero/NaR override.
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears all stage registers
//   ld1..3   in   stage load enables
//   op       in   {fir, frac_lsb_cut_off}, fir = {sign, te, frac}
//   special  in   2'b00 normal, 2'b01 zero, 2'b1x NaR
//   posit    out  registered S3 result
module fir_to_posit_lane
    import ppu_pkg::*;
#(
    parameter int N              = 16,
    parameter int ES             = 1,
    parameter int FIR_TOTAL_SIZE = 43
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld1,
    input  logic                    ld2,
    input  logic                    ld3,
    input  logic [FIR_TOTAL_SIZE:0] op,
    input  logic [1:0]              special,
    output logic [N-1:0]            posit
);

    localparam int TE = te_size(N, ES);
    localparam int FF = FIR_TOTAL_SIZE - 1 - TE;
    localparam int T  = ES + FF;            // exp + fraction tail behind the regime
    localparam int M  = N + 2 + T;          // alignment window, N guard zeros at the bottom
    localparam int SW = $clog2(M);
    localparam logic [63:0]  NAR_W  = nar_val(N);
    localparam logic [N-1:0] NAR_P  = NAR_W[N-1:0];
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = N'(1);

    // ---------------- field extraction ----------------
    logic                 sign;
    logic                 cut;
    logic signed [TE-1:0] te;
    logic signed [TE-1:0] k;
    logic [FF-1:0]        frac;
    logic [T-1:0]         tail;

    assign cut  = op[0];
    assign frac = op[FF:1];
    assign te   = op[FF+1 +: TE];
    assign sign = op[FIR_TOTAL_SIZE];
    assign k    = te >>> ES;

    generate
        if (ES > 0) begin : g_es
            assign tail = {te[ES-1:0], frac};
        end else begin : g_no_es
            assign tail = frac;
        end
    endgenerate

    // ---------------- S1 combinational ----------------
    int           k_int;
    int           s_int;
    logic [SW-1:0] shamt;
    logic [M-1:0] vx;
    logic [M-1:0] sh_pos;
    logic [M-1:0] sh_neg;
    logic [M-1:0] sh;
    logic         sat_max_c;
    logic         sat_min_c;

    // The regime is produced by shifting a two-bit seed in front of the tail:
    // for k >= 0 the seed 10 is arithmetically shifted by k (sign-filling ones),
    // for k < 0 the seed 01 is logically shifted by -k-1 (filling zeros).
    always_comb begin
        k_int     = int'(k);
        sat_max_c = (k_int >= N - 2);
        sat_min_c = (k_int <= -(N - 1));
        s_int     = (k_int >= 0) ? k_int : (-k_int - 1);
        if (s_int > N - 1) begin
            s_int = N - 1;               // saturated lanes; keeps the shift in range
        end
        shamt  = s_int[SW-1:0];
        vx     = {((k_int >= 0) ? 2'b10 : 2'b01), tail, {N{1'b0}}};
        sh_pos = $signed(vx) >>> shamt;
        sh_neg = vx >> shamt;
        sh     = (k_int >= 0) ? sh_pos : sh_neg;
    end

    logic           s1_sign_reg;
    logic           s1_cut_reg;
    logic [1:0]     s1_special_reg;
    logic           s1_sat_max_reg;
    logic           s1_sat_min_reg;
    logic [N-2:0]   s1_body_reg;
    logic           s1_round_reg;
    logic           s1_sticky_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign_reg    <= 1'b0;
            s1_cut_reg     <= 1'b0;
            s1_special_reg <= 2'b00;
            s1_sat_max_reg <= 1'b0;
            s1_sat_min_reg <= 1'b0;
            s1_body_reg    <= '0;
            s1_round_reg   <= 1'b0;
            s1_sticky_reg  <= 1'b0;
        end else if (ld1) begin
            s1_sign_reg    <= sign;
            s1_cut_reg     <= cut;
            s1_special_reg <= special;
            s1_sat_max_reg <= sat_max_c;
            s1_sat_min_reg <= sat_min_c;
            s1_body_reg    <= sh[M-1 -: N-1];
            s1_round_reg   <= sh[M-N];
            s1_sticky_reg  <= |sh[M-N-1:0];
        end
    end

    // ---------------- S2 combinational ----------------
    logic [N-1:0] p_next;
    logic         rnd_next;

    // Saturated lanes never round, so the result cannot reach 0 or NaR.
    always_comb begin
        if (s1_sat_max_reg) begin
            p_next = MAXPOS;
        end else if (s1_sat_min_reg) begin
            p_next = MINPOS;
        end else begin
            p_next = {1'b0, s1_body_reg};
        end
        rnd_next = !s1_sat_max_reg && !s1_sat_min_reg && s1_round_reg &&
                   (s1_sticky_reg || s1_body_reg[0] || s1_cut_reg);
    end

    logic [N-1:0] s2_p_reg;
    logic         s2_rnd_reg;
    logic         s2_sign_reg;
    logic [1:0]   s2_special_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_p_reg       <= '0;
            s2_rnd_reg     <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_special_reg <= 2'b00;
        end else if (ld2) begin
            s2_p_reg       <= p_next;
            s2_rnd_reg     <= rnd_next;
            s2_sign_reg    <= s1_sign_reg;
            s2_special_reg <= s1_special_reg;
        end
    end

    // ---------------- S3 combinational ----------------
    logic [N-1:0] mag;
    logic [N-1:0] res_next;

    always_comb begin
        mag = s2_p_reg + {{(N-1){1'b0}}, s2_rnd_reg};
        if (s2_special_reg == ZERO) begin
            res_next = '0;
        end else if (s2_special_reg[1]) begin
            res_next = NAR_P;
        end else if (s2_sign_reg) begin
            res_next = N'(0) - mag;
        end else begin
            res_next = mag;
        end
    end

    logic [N-1:0] s3_posit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_posit_reg <= '0;
        end else if (ld3) begin
            s3_posit_reg <= res_next;
        end
    end

    assign posit = s3_posit_reg;

endmodule

// File: rtl/fir_to_posit_pipe.sv
// fir_to_posit_pipe
//   Multi-lane 3-stage FIR-to-posit converter with valid/ready flow control.
//   Owns the stage valids (bubble-collapsing advance) and, optionally, a
//   2-entry output skid buffer. Lane datapaths live in fir_to_posit_lane.
// Configuration macro
//   FIR2P_SKID_EN : adds a 2-entry skid buffer after S3; in_ready and all stage
//                   advances then depend only on registered state (latency 4).
//                   Undefined: combinational ready chain, latency 3.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input beat valid
//   in_ready   out  pipe accepts a beat this cycle
//   in_ops     in   LANES x {fir, frac_lsb_cut_off}
//   in_special in   LANES x 2-bit special tag
//   out_valid  out  output beat valid
//   out_ready  in   consumer accepts the beat
//   out_posit  out  LANES x N-bit posit
module fir_to_posit_pipe
    import ppu_pkg::*;
#(
    parameter int N              = 16,
    parameter int ES             = 1,
    parameter int FIR_TOTAL_SIZE = 43,
    parameter int LANES          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*(FIR_TOTAL_SIZE+1)-1:0] in_ops,
    input  logic [LANES*2-1:0]                in_special,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*N-1:0]                out_posit
);

    localparam int OPW = FIR_TOTAL_SIZE + 1;

    logic v1_reg;
    logic v2_reg;
    logic v3_reg;
    logic adv1;
    logic adv2;
    logic adv3;
    logic ld1;
    logic ld2;
    logic ld3;
    logic [LANES*N-1:0] s3_posit;

    // Data registers only capture real beats; empty slots simply hold.
    assign adv2     = !v2_reg || adv3;
    assign adv1     = !v1_reg || adv2;
    assign in_ready = adv1;
    assign ld1      = adv1 && in_valid;
    assign ld2      = adv2 && v1_reg;
    assign ld3      = adv3 && v2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            if (adv1) v1_reg <= in_valid;
            if (adv2) v2_reg <= v1_reg;
            if (adv3) v3_reg <= v2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            fir_to_posit_lane #(
                .N              (N),
                .ES             (ES),
                .FIR_TOTAL_SIZE (FIR_TOTAL_SIZE)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .ld1     (ld1),
                .ld2     (ld2),
                .ld3     (ld3),
                .op      (in_ops[gi*OPW +: OPW]),
                .special (in_special[gi*2 +: 2]),
                .posit   (s3_posit[gi*N +: N])
            );
        end
    endgenerate

`ifdef FIR2P_SKID_EN
    // S3 drains into the skid whenever it has room; the room test uses the
    // registered count only, so out_ready never reaches in_ready combinationally.
    logic [LANES*N-1:0] skid_mem_reg [2];
    logic               skid_wr_reg;
    logic               skid_rd_reg;
    logic [1:0]         skid_cnt_reg;
    logic               push;
    logic               pop;

    assign adv3      = !v3_reg || (skid_cnt_reg != 2'd2);
    assign push      = adv3 && v3_reg;
    assign out_valid = (skid_cnt_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_posit = skid_mem_reg[skid_rd_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                skid_mem_reg[i] <= '0;
            end
            skid_wr_reg  <= 1'b0;
            skid_rd_reg  <= 1'b0;
            skid_cnt_reg <= 2'd0;
        end else begin
            if (push) begin
                skid_mem_reg[skid_wr_reg] <= s3_posit;
                skid_wr_reg               <= ~skid_wr_reg;
            end
            if (pop) begin
                skid_rd_reg <= ~skid_rd_reg;
            end
            skid_cnt_reg <= skid_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end
`else
    assign adv3      = !v3_reg || out_ready;
    assign out_valid = v3_reg;
    assign out_posit = s3_posit;
`endif

endmodule

// File: tb/tb_fir_to_posit_pipe.sv
module tb_fir_to_posit_pipe;

    localparam int N     = 16;
    localparam int ES    = 1;
    localparam int FIRW  = 43;
    localparam int LANES = 4;
    localparam int OPW   = FIRW + 1;
    localparam int NBEAT = 20;
`ifdef FIR2P_SKID_EN
    localparam int LAT   = 4;
`else
    localparam int LAT   = 3;
`endif

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*OPW-1:0]   in_ops;
    logic [LANES*2-1:0]     in_special;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*N-1:0]     out_posit;

    int checks;
    int failures;

    fir_to_posit_pipe #(
        .N(N), .ES(ES), .FIR_TOTAL_SIZE(FIRW), .LANES(LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ops     (in_ops),
        .in_special (in_special),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack one lane as {sign, te[6:0], frac[34:0], cut_off}.
    function automatic logic [OPW-1:0] pack_lane(input bit sgn, input int te,
                                                 input logic [34:0] frac, input bit cut);
        logic [6:0] t7;
        t7 = te[6:0];
        return {sgn, t7, frac, cut};
    endfunction

    // Reference: write out the posit bit string (regime run, exponent bit,
    // fraction) and cut it at N-1 body bits, then round to nearest even.
    function automatic logic [15:0] ref_posit(input bit sgn, input int te,
                                              input logic [34:0] frac, input bit cut,
                                              input logic [1:0] sp);
        int          k;
        int          e;
        bit          q[$];
        logic [14:0] body;
        bit          rb;
        bit          st;
        logic [15:0] p;
        if (sp == 2'b01) return 16'h0000;
        if (sp[1])       return 16'h8000;
        k = te >>> 1;
        e = te & 1;
        if (k >= 14) begin
            p = 16'h7FFF;
        end else if (k <= -15) begin
            p = 16'h0001;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[0]);
            for (int i = 34; i >= 0; i--) q.push_back(frac[i]);
            body = '0;
            for (int i = 0; i < 15; i++) body = {body[13:0], q[i]};
            rb = q[15];
            st = 1'b0;
            for (int i = 16; i < q.size(); i++) st = st | q[i];
            p = {1'b0, body};
            if (rb && (st || body[0] || cut)) p = p + 16'd1;
        end
        return sgn ? (16'd0 - p) : p;
    endfunction

    // Drive one beat into an idle pipe and wait (bounded) for its result.
    task automatic run_beat(input logic [LANES*OPW-1:0] ops, input logic [7:0] sp,
                            output int lat, output logic [LANES*N-1:0] got);
        in_ops     = ops;
        in_special = sp;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        got = '0;
        for (int c = 1; c <= 10; c++) begin
            if (out_valid) begin
                lat = c;
                got = out_posit;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_ops = '0; in_special = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_posit !== '0) begin failures++; $display("FAIL reset_out_posit got=%h exp=0", out_posit); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("reset: out_valid=%b out_posit=%h in_ready=%b", out_valid, out_posit, in_ready);
    endtask

    task automatic test_unity();
        int lat;
        logic [LANES*N-1:0] got;
        logic [OPW-1:0] l;
        for (int s = 0; s < 2; s++) begin
            l = pack_lane(s[0], 0, 35'd0, 1'b0);
            run_beat({l, l, l, l}, 8'h00, lat, got);
            $display("unity sign=%0d: latency=%0d out=%h", s, lat, got);
            checks++;
            if (lat != LAT) begin failures++; $display("FAIL unity_latency got=%0d exp=%0d", lat, LAT); end
            for (int i = 0; i < LANES; i++) begin
                checks++;
                if (got[i*N +: N] !== ((s == 0) ? 16'h4000 : 16'hC000)) begin
                    failures++;
                    $display("FAIL unity_lane%0d got=%h exp=%h", i, got[i*N +: N], (s == 0) ? 16'h4000 : 16'hC000);
                end
            end
        end
    endtask

    task automatic test_specials();
        int lat;
        logic [LANES*N-1:0] got;
        logic [63:0] expv;
        expv = {16'hD000, 16'h5000, 16'h8000, 16'h0000};
        run_beat({pack_lane(1'b1, -1, 35'd0, 1'b0), pack_lane(1'b0, 1, 35'd0, 1'b0),
                  pack_lane(1'b1, 5, 35'h123456789, 1'b1), pack_lane(1'b1, 3, 35'h7FFFFFFFF, 1'b1)},
                 {2'b00, 2'b00, 2'b10, 2'b01}, lat, got);
        $display("specials: latency=%0d out=%h", lat, got);
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (got[i*N +: N] !== expv[i*16 +: 16]) begin
                failures++;
                $display("FAIL specials_lane%0d got=%h exp=%h", i, got[i*N +: N], expv[i*16 +: 16]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [LANES*N-1:0] got;
        logic [63:0] expv;
        expv = {16'hFFFF, 16'h8001, 16'h0001, 16'h7FFF};
        run_beat({pack_lane(1'b1, -60, 35'h7FFFFFFFF, 1'b1), pack_lane(1'b1, 60, 35'h7FFFFFFFF, 1'b1),
                  pack_lane(1'b0, -60, 35'd0, 1'b0), pack_lane(1'b0, 60, 35'd0, 1'b0)},
                 8'h00, lat, got);
        $display("saturation: latency=%0d out=%h", lat, got);
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (got[i*N +: N] !== expv[i*16 +: 16]) begin
                failures++;
                $display("FAIL saturation_lane%0d got=%h exp=%h", i, got[i*N +: N], expv[i*16 +: 16]);
            end
        end
    endtask

    task automatic test_ties();
        int lat;
        logic [LANES*N-1:0] got;
        logic [63:0] expv;
        logic [34:0] half;
        half = 35'd1 << 22;   // round bit for te=0 (12 fraction bits kept)
        // lane0 exact tie, even lsb; lane1 tie + cut_off; lane2 tie, odd lsb; lane3 sticky set
        expv = {16'h4001, 16'h4002, 16'h4001, 16'h4000};
        run_beat({pack_lane(1'b0, 0, half | 35'd1, 1'b0), pack_lane(1'b0, 0, half | (35'd1 << 23), 1'b0),
                  pack_lane(1'b0, 0, half, 1'b1), pack_lane(1'b0, 0, half, 1'b0)},
                 8'h00, lat, got);
        $display("ties: latency=%0d out=%h", lat, got);
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (got[i*N +: N] !== expv[i*16 +: 16]) begin
                failures++;
                $display("FAIL ties_lane%0d got=%h exp=%h", i, got[i*N +: N], expv[i*16 +: 16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*N-1:0] sb[$];
        logic [LANES*N-1:0] cur_exp;
        logic [LANES*N-1:0] held;
        logic [63:0] r;
        bit   have_beat;
        bit   stalled;
        bit   in_fire;
        bit   out_fire;
        int   sent;
        int   recv;
        int   occ;
        int   cyc;
        bit   sgn;
        bit   cut;
        int   te;
        logic [1:0] sp;
        have_beat = 0; stalled = 0; sent = 0; recv = 0; occ = 0; cyc = 0;
        held = '0; cur_exp = '0;
        while (recv < NBEAT && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (!have_beat && sent < NBEAT) begin
                for (int i = 0; i < LANES; i++) begin
                    r   = {$urandom(), $urandom()};
                    sgn = r[63];
                    cut = r[62];
                    te  = int'($urandom_range(0, 127)) - 64;
                    sp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    in_ops[i*OPW +: OPW] = pack_lane(sgn, te, r[34:0], cut);
                    in_special[i*2 +: 2] = sp;
                    cur_exp[i*N +: N]    = ref_posit(sgn, te, r[34:0], cut, sp);
                end
                have_beat = 1;
            end
            in_valid  = have_beat;
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (stalled) begin
                checks++;
                if (!out_valid || out_posit !== held) begin
                    failures++;
                    $display("FAIL stall_stable got=%h/%b exp=%h/1", out_posit, out_valid, held);
                end
            end
            if (!in_ready) begin
                checks++;
`ifdef FIR2P_SKID_EN
                if (occ != 5) begin
`else
                if (!(occ == 3 && !out_ready)) begin
`endif
                    failures++;
                    $display("FAIL in_ready_drop got=0 occupancy=%0d out_ready=%b exp=1", occ, out_ready);
                end
            end
            if (out_fire) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_beat got=%h exp=none", out_posit);
                end else begin
                    if (out_posit !== sb[0]) begin
                        failures++;
                        $display("FAIL b2b_beat%0d got=%h exp=%h", recv, out_posit, sb[0]);
                    end
                    $display("b2b beat %0d: out=%h exp=%h", recv, out_posit, sb[0]);
                    void'(sb.pop_front());
                end
                recv++;
                occ--;
            end
            if (in_fire) begin
                sb.push_back(cur_exp);
                have_beat = 0;
                sent++;
                occ++;
            end
            stalled = out_valid && !out_ready;
            held    = out_posit;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != NBEAT || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d pending=%0d exp=%0d pending=0", recv, sb.size(), NBEAT);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_duplicate got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        int lat;
        logic [LANES*N-1:0] got;
        logic [OPW-1:0] l;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            l = pack_lane(1'b0, 7 + b, 35'h1F0F0F0F0, 1'b0);
            in_ops = {l, l, l, l};
            in_special = '0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flight_reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL flight_reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
        l = pack_lane(1'b1, 0, 35'd0, 1'b0);
        run_beat({l, l, l, l}, 8'h00, lat, got);
        $display("reset in flight: new beat latency=%0d out=%h", lat, got);
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL flight_latency got=%0d exp=%0d", lat, LAT); end
        checks++;
        if (got !== {4{16'hC000}}) begin failures++; $display("FAIL flight_value got=%h exp=%h", got, {4{16'hC000}}); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_unity();
        test_specials();
        test_saturation();
        test_ties();
        test_back_to_back();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
